// File: rtl/sound_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sound_scheduler_pkg
//  Purpose  : Shared types and constants for the sound scheduler.
//             Provides the mode enum, the scheduler state enum and the fixed
//             two-note table, indexed by requester and note.
//  Revision : 1.0 - initial release
// ============================================================================
package sound_scheduler_pkg;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } MODE_TYPES;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } sched_state_e;

    // NOTE_ROM[owner][note]; the rightmost literal lands at [0][0].
    localparam logic [3:0][1:0][7:0] NOTE_ROM = {
        8'd25,  8'd255,   // owner 3
        8'd150, 8'd200,   // owner 2
        8'd120, 8'd100,   // owner 1
        8'd40,  8'd50     // owner 0
    };

    function automatic logic [7:0] note_freq(input logic [1:0] owner, input logic note);
        return NOTE_ROM[owner][note];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Picks the first pending requester found
//             when scanning upward from (last_i + 1) mod NREQ.
//  Ports    : pending_i [NREQ]  sticky request flags
//             last_i    [IW]    index of the most recently served requester
//             grant_o   [NREQ]  one-hot winner, all-zero if nothing pending
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] pending_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] grant_o
);

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_i) + k) % NREQ);
            if (!found && pending_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sound_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sound_scheduler
//  Purpose  : Shares one oscillator between NREQ requesters. Each served
//             requester gets a two-note sequence: note 0 for DUR cycles,
//             GAP silent cycles, note 1 for DUR cycles, then an ack.
//  Ports    : clk, nRst (async, active-low)
//             mode      OFF/ON global enable
//             req       per-requester one-cycle request strobes
//             freq      registered oscillator period code
//             playSound registered one-cycle oscillator (re)start strobe
//             grant     one-hot current owner, zero when idle
//             ack       one-cycle completion strobe for the owner
//             busy      high whenever not idle
//  Revision : 1.0 - initial release
// ============================================================================
module sound_scheduler
    import sound_scheduler_pkg::*;
#(
    parameter int          NREQ = 4,
    parameter logic [23:0] DUR  = 24'd10_000_000,
    parameter logic [15:0] GAP  = 16'd50_000
) (
    input  logic            clk,
    input  logic            nRst,
    input  MODE_TYPES       mode,
    input  logic [NREQ-1:0] req,
    output logic [7:0]      freq,
    output logic            playSound,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] ack,
    output logic            busy
);

    localparam int          IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [23:0] DUR_LAST = DUR - 24'd1;
    localparam logic [15:0] GAP_LAST = GAP - 16'd1;

    sched_state_e    state_q,   state_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic            rearm_q,   rearm_d;    // owner re-requested while being served
    logic [IW-1:0]   owner_q,   owner_d;
    logic [IW-1:0]   last_q,    last_d;
    logic            note_q,    note_d;
    logic [23:0]     dur_q,     dur_d;
    logic [15:0]     gap_q,     gap_d;
    logic [7:0]      freq_q,    freq_d;
    logic            play_q,    play_d;

    logic [NREQ-1:0] w_arb_grant;
    logic [IW-1:0]   w_arb_idx;
    logic [NREQ-1:0] w_owner_onehot;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .pending_i (pending_q),
        .last_i    (last_q),
        .grant_o   (w_arb_grant)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_grant[i]) w_arb_idx = IW'(i);
        end
    end

    assign w_owner_onehot = NREQ'(1) << owner_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | req;
        rearm_d   = rearm_q;
        owner_d   = owner_q;
        last_d    = last_q;
        note_d    = note_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        freq_d    = freq_q;
        play_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    owner_d = w_arb_idx;
                    note_d  = 1'b0;
                    rearm_d = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                play_d  = 1'b1;
                freq_d  = note_freq(2'(owner_q), note_q);
                rearm_d = rearm_q | req[owner_q];
                dur_d   = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                rearm_d = rearm_q | req[owner_q];
                if (dur_q == DUR_LAST) begin
                    dur_d   = '0;
                    gap_d   = '0;
                    state_d = note_q ? S_DONE : S_GAP;
                end else begin
                    dur_d = dur_q + 24'd1;
                end
            end
            S_GAP: begin
                rearm_d = rearm_q | req[owner_q];
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    note_d  = 1'b1;
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_DONE: begin
                // A fresh request in this cycle (or one seen during service)
                // keeps the owner pending so the sequence replays later.
                pending_d[owner_q] = rearm_q | req[owner_q];
                last_d             = owner_q;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (mode == OFF) begin
            state_d   = S_IDLE;
            pending_d = '0;
            rearm_d   = 1'b0;
            last_d    = last_q;
            note_d    = 1'b0;
            dur_d     = '0;
            gap_d     = '0;
            freq_d    = '0;
            play_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            rearm_q   <= 1'b0;
            owner_q   <= '0;
            last_q    <= IW'(NREQ - 1);
            note_q    <= 1'b0;
            dur_q     <= '0;
            gap_q     <= '0;
            freq_q    <= '0;
            play_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rearm_q   <= rearm_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            note_q    <= note_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            freq_q    <= freq_d;
            play_q    <= play_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign grant     = busy ? w_owner_onehot : '0;
    assign ack       = ((state_q == S_DONE) && (mode == ON)) ? w_owner_onehot : '0;
    assign freq      = freq_q;
    assign playSound = play_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sound_scheduler
//  Purpose  : Self-checking bench for sound_scheduler (DUR=20, GAP=5).
//             A sequence is modelled as an offset k from its first granted
//             cycle; outputs are derived from that offset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sound_scheduler;
    import sound_scheduler_pkg::*;

    localparam int DURC = 20;
    localparam int GAPC = 5;
    localparam int L    = 2 * DURC + GAPC + 3;   // cycles from grant to ack inclusive

    logic      clk  = 1'b0;
    logic      nRst = 1'b0;
    MODE_TYPES mode = OFF;
    logic [3:0] req = 4'b0000;
    logic [7:0] freq;
    logic       playSound;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       busy;

    sound_scheduler #(
        .NREQ (4),
        .DUR  (24'd20),
        .GAP  (16'd5)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .mode      (mode),
        .req       (req),
        .freq      (freq),
        .playSound (playSound),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int f0_tab [4] = '{50, 100, 200, 255};
    int f1_tab [4] = '{40, 120, 150, 25};

    // model state
    logic [3:0] m_pending = '0;
    bit         m_active  = 0;
    int         m_owner   = 0;
    int         m_k       = 0;
    bit         m_rearm   = 0;
    int         m_last    = 3;
    int         m_freq    = 0;

    int play_log[$];
    int play_t[$];
    int ack_log[$];
    int ack_t[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void model_step();
        logic [3:0] np;
        bit found;
        if (!nRst) begin
            m_pending = '0; m_active = 0; m_owner = 0; m_k = 0;
            m_rearm = 0; m_last = 3; m_freq = 0;
            return;
        end
        if (mode == OFF) begin
            m_pending = '0; m_active = 0; m_rearm = 0; m_freq = 0;
            return;
        end
        np = m_pending | req;
        if (m_active) begin
            if (m_k == 0)               m_freq = f0_tab[m_owner];
            if (m_k == DURC + GAPC + 1) m_freq = f1_tab[m_owner];
            if (m_k == L - 1) begin
                np[m_owner] = m_rearm | req[m_owner];
                m_last   = m_owner;
                m_active = 0;
            end else begin
                if (req[m_owner]) m_rearm = 1;
                m_k++;
            end
        end else if (m_pending != 0) begin
            found = 0;
            for (int o = 1; o <= 4; o++) begin
                if (!found && m_pending[(m_last + o) % 4]) begin
                    m_owner = (m_last + o) % 4;
                    found   = 1;
                end
            end
            m_active = 1; m_k = 0; m_rearm = 0;
        end
        m_pending = np;
    endfunction

    // Model update at each edge, then compare outputs mid-cycle.
    always @(posedge clk) begin
        model_step();
        #2;
        cyc++;
        check("grant", int'(grant), m_active ? (1 << m_owner) : 0);
        check("busy", int'(busy), int'(m_active));
        check("ack", int'(ack), (m_active && m_k == L - 1 && mode == ON) ? (1 << m_owner) : 0);
        check("playSound", int'(playSound),
              int'(m_active && (m_k == 1 || m_k == DURC + GAPC + 2)));
        check("freq", int'(freq), m_freq);
        if (playSound) begin
            play_log.push_back(int'(freq));
            play_t.push_back(cyc);
        end
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                ack_log.push_back(i);
                ack_t.push_back(cyc);
            end
        end
    end

    task automatic clear_logs();
        play_log.delete(); play_t.delete(); ack_log.delete(); ack_t.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b0; req = '0; mode = OFF;
        repeat (2) @(negedge clk);
        nRst = 1'b1; mode = ON;
        clear_logs();
    endtask

    task automatic pulse(input logic [3:0] v);
        @(negedge clk); req = v;
        @(negedge clk); req = '0;
    endtask

    task automatic wait_idle(input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!ok && !m_active && m_pending == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_play(input int n, input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (play_log.size() >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_play_timeout", 1, 0);
    endtask

    initial begin
        bit seen;

        // reset values while nRst is held low
        #1;
        check("rst_freq", int'(freq), 0);
        check("rst_play", int'(playSound), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);

        // single request: latency and full two-note sequence
        do_reset();
        req = 4'b0001;
        @(posedge clk); #3;
        check("lat_grant_e1", int'(grant), 0);
        @(negedge clk); req = '0;
        @(posedge clk); #3;
        check("lat_grant_e2", int'(grant), 1);
        check("lat_play_e2", int'(playSound), 0);
        @(posedge clk); #3;
        check("lat_play_e3", int'(playSound), 1);
        check("lat_freq_e3", int'(freq), 50);
        wait_idle(200);
        check("s1_nplays", play_log.size(), 2);
        check("s1_f0", qget(play_log, 0), 50);
        check("s1_f1", qget(play_log, 1), 40);
        check("s1_note_spacing", qget(play_t, 1) - qget(play_t, 0), DURC + GAPC + 1);
        check("s1_nacks", ack_log.size(), 1);
        check("s1_ack_owner", qget(ack_log, 0), 0);
        check("s1_ack_delay", qget(ack_t, 0) - qget(play_t, 0), L - 2);

        // simultaneous requests 1 and 3
        do_reset();
        pulse(4'b1010);
        wait_idle(300);
        check("s2_nplays", play_log.size(), 4);
        check("s2_p0", qget(play_log, 0), 100);
        check("s2_p1", qget(play_log, 1), 120);
        check("s2_p2", qget(play_log, 2), 255);
        check("s2_p3", qget(play_log, 3), 25);
        check("s2_ack0", qget(ack_log, 0), 1);
        check("s2_ack1", qget(ack_log, 1), 3);

        // re-requests during own PLAY and in DONE merge into one replay
        do_reset();
        pulse(4'b0100);
        wait_play(1, 50);
        repeat (3) @(negedge clk);
        pulse(4'b0100);
        repeat (3) @(negedge clk);
        pulse(4'b0100);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack != 0) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("s3_done_timeout", 1, 0);
        req = 4'b0100;
        @(negedge clk); req = '0;
        wait_idle(400);
        repeat (60) @(negedge clk);
        check("s3_nplays", play_log.size(), 4);
        check("s3_p2", qget(play_log, 2), 200);
        check("s3_p3", qget(play_log, 3), 150);
        check("s3_nacks", ack_log.size(), 2);
        check("s3_ack1", qget(ack_log, 1), 2);

        // mode OFF mid-PLAY
        do_reset();
        pulse(4'b0001);
        wait_play(1, 50);
        repeat (5) @(negedge clk);
        mode = OFF;
        @(posedge clk); #3;
        check("s4_busy", int'(busy), 0);
        check("s4_grant", int'(grant), 0);
        check("s4_freq", int'(freq), 0);
        @(negedge clk); req = 4'b0001;
        @(negedge clk); req = '0;
        @(negedge clk); mode = ON;
        repeat (150) @(negedge clk);
        check("s4_nplays", play_log.size(), 1);
        check("s4_nacks", ack_log.size(), 0);

        // reset in GAP
        do_reset();
        pulse(4'b0001);
        wait_play(1, 50);
        repeat (22) @(negedge clk);
        nRst = 1'b0;
        #1;
        check("s5_freq", int'(freq), 0);
        check("s5_play", int'(playSound), 0);
        check("s5_grant", int'(grant), 0);
        check("s5_ack", int'(ack), 0);
        check("s5_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        pulse(4'b0001);
        wait_idle(200);
        check("s5_nplays", play_log.size(), 3);
        check("s5_p1", qget(play_log, 1), 50);
        check("s5_p2", qget(play_log, 2), 40);
        check("s5_nacks", ack_log.size(), 1);

        // all four continuously pending
        do_reset();
        @(negedge clk); req = 4'b1111;
        repeat (5 * L + 10) @(negedge clk);
        req = '0;
        wait_idle(600);
        check("s6_a0", qget(ack_log, 0), 0);
        check("s6_a1", qget(ack_log, 1), 1);
        check("s6_a2", qget(ack_log, 2), 2);
        check("s6_a3", qget(ack_log, 3), 3);
        check("s6_a4", qget(ack_log, 4), 0);

        // randomized traffic, mode toggles and occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            req = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 299) == 0) mode = (mode == ON) ? OFF : ON;
            nRst = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        req = '0; nRst = 1'b1; mode = ON;
        wait_idle(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
